// File: rtl/jk_ff_bank_pkg.sv
// Shared types for the jk_ff_bank register bank: per-cycle update mode encoding.
package jk_ff_bank_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_JK = 2'b00,
        MODE_D  = 2'b01,
        MODE_T  = 2'b10,
        MODE_SR = 2'b11
    } ff_mode_e;

endpackage

// File: rtl/jk_ff_bank_next.sv
// Single-bit next-state logic for jk_ff_bank: JK / D / T / SR selected by mode.
// illegal flags the forbidden S=R=1 combination in SR mode; the bit then holds.
module jk_ff_bank_next
    import jk_ff_bank_pkg::*;
(
    input  ff_mode_e mode,
    input  logic     a,
    input  logic     b,
    input  logic     q,
    output logic     q_next,
    output logic     illegal
);

    always_comb begin
        q_next  = q;
        illegal = 1'b0;
        unique case (mode)
            MODE_JK: begin
                unique case ({a, b})
                    2'b00: q_next = q;
                    2'b01: q_next = 1'b0;
                    2'b10: q_next = 1'b1;
                    2'b11: q_next = ~q;
                endcase
            end
            MODE_D:  q_next = a;
            MODE_T:  q_next = a ? ~q : q;
            MODE_SR: begin
                unique case ({a, b})
                    2'b00: q_next = q;
                    2'b01: q_next = 1'b0;
                    2'b10: q_next = 1'b1;
                    2'b11: begin
                        q_next  = q;
                        illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/jk_ff_bank.sv
// WIDTH-bit JK/D/T/SR flip-flop bank with sync clear/set, enable and sticky SR error.
// Optional parity register is built when JK_FF_BANK_PARITY_EN is defined.
module jk_ff_bank
    import jk_ff_bank_pkg::*;
#(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                clr,
    input  logic                set,
    input  logic [MODE_W-1:0]   mode,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                sr_err_clr,
    output logic [WIDTH-1:0]    q,
    output logic [WIDTH-1:0]    q_n,
    output logic                sr_err,
    output logic                parity
);

    ff_mode_e           mode_e;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   q_mode;
    logic [WIDTH-1:0]   illegal_bits;
    logic [WIDTH-1:0]   q_d;
    logic               err_event;
    logic               err_reg;

    assign mode_e = ff_mode_e'(mode);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_ff_bank_next u_next (
            .mode    (mode_e),
            .a       (a[i]),
            .b       (b[i]),
            .q       (q_reg[i]),
            .q_next  (q_mode[i]),
            .illegal (illegal_bits[i])
        );
    end

    always_comb begin
        q_d = q_reg;
        if (clr)
            q_d = '0;
        else if (set)
            q_d = '1;
        else if (en)
            q_d = q_mode;
    end

    // illegal_bits is only meaningful in SR mode; gated here so clr/set mask it too
    assign err_event = en && !clr && !set && (mode_e == MODE_SR) && (|illegal_bits);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_reg   <= RESET_VAL;
            err_reg <= 1'b0;
        end else begin
            q_reg <= q_d;
            if (err_event)
                err_reg <= 1'b1;
            else if (sr_err_clr)
                err_reg <= 1'b0;
        end
    end

`ifdef JK_FF_BANK_PARITY_EN
    logic parity_reg;

    // registered from q_d so parity tracks q on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            parity_reg <= ^RESET_VAL;
        else
            parity_reg <= ^q_d;
    end

    assign parity = parity_reg;
`else
    assign parity = 1'b0;
`endif

    assign q      = q_reg;
    assign q_n    = ~q_reg;
    assign sr_err = err_reg;

endmodule
